// File: rtl/dutb_param_pkg.sv
// Shared types and defaults for the dutb fail monitor: stop causes, FSM states
// and the fail_total width helper.
package dutb_param_pkg;

  localparam int DUTB_MAX_FAIL_NUM_DEF = 16;

  typedef enum logic [1:0] {
    STOP_NONE    = 2'b00,
    STOP_FAIL    = 2'b01,
    STOP_TIMEOUT = 2'b10
  } stop_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DRAIN   = 2'b10,
    ST_STOPPED = 2'b11
  } fail_mon_state_t;

  // A budget of 0 still needs a 1-bit fail_total port.
  function automatic int fail_total_width(input int max_fail);
    return (max_fail > 0) ? $clog2(max_fail + 1) : 1;
  endfunction

endpackage

// File: rtl/dutb_sat_counter.sv
// Saturating up-counter: adds inc_i each cycle, clamps at P_MAX, synchronous clear.
module dutb_sat_counter #(
  parameter int             P_W     = 8,
  parameter int             P_INC_W = 1,
  parameter logic [P_W-1:0] P_MAX   = '1
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic [P_INC_W-1:0] inc_i,
  output logic [P_W-1:0]     cnt_o
);

  // One extra bit so the pre-clamp sum cannot wrap.
  localparam int SW = ((P_W > P_INC_W) ? P_W : P_INC_W) + 1;

  logic [P_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]  sum;

  always_comb begin
    sum   = SW'(cnt_q) + SW'(inc_i);
    cnt_d = (sum > SW'(P_MAX)) ? P_MAX : sum[P_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dutb_fail_monitor.sv
// Multi-channel pass/fail tracker issuing a stop request on fail budget or idle timeout.
// Build option: DUTB_FAIL_MON_TIMEOUT_EN adds the idle timer and the timeout stop path.
//
// state      | meaning
// IDLE       | waiting for enable, verdicts ignored
// RUN        | counting verdicts, watching budget and idle timer
// DRAIN      | stop_req high, still counting, waiting for stop_ack
// STOPPED    | done, verdicts ignored until reset
module dutb_fail_monitor
  import dutb_param_pkg::*;
#(
  parameter int P_CH_NUM       = 4,
  parameter int P_MAX_FAIL_NUM = DUTB_MAX_FAIL_NUM_DEF,
  parameter int P_CNT_WIDTH    = 16,
  parameter int P_TIMEOUT      = 1024
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        enable,
  input  logic [P_CH_NUM-1:0]                         chk_valid,
  input  logic [P_CH_NUM-1:0]                         chk_pass,
  output logic [P_CH_NUM*P_CNT_WIDTH-1:0]             pass_cnt,
  output logic [P_CH_NUM*P_CNT_WIDTH-1:0]             fail_cnt,
  output logic [fail_total_width(P_MAX_FAIL_NUM)-1:0] fail_total,
  output logic                                        stop_req,
  input  logic                                        stop_ack,
  output logic [1:0]                                  stop_cause,
  output logic                                        done
);

  localparam int FW = fail_total_width(P_MAX_FAIL_NUM);
  localparam int IW = $clog2(P_CH_NUM + 1);

  fail_mon_state_t state_q, state_d;
  stop_cause_t     cause_q, cause_d;
  logic            stop_req_q, stop_req_d;
  logic            done_q, done_d;

  logic                counting;
  logic [P_CH_NUM-1:0] pass_hit, fail_hit;
  logic [IW-1:0]       fail_inc;
  logic                budget_hit, timeout_hit;

  assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign pass_hit = counting ? (chk_valid & chk_pass)  : '0;
  assign fail_hit = counting ? (chk_valid & ~chk_pass) : '0;

  always_comb begin
    fail_inc = '0;
    for (int c = 0; c < P_CH_NUM; c++) fail_inc = fail_inc + IW'(fail_hit[c]);
  end

  for (genvar c = 0; c < P_CH_NUM; c++) begin : g_ch
    dutb_sat_counter #(.P_W(P_CNT_WIDTH), .P_INC_W(1)) u_pass (
      .clk_i (clk),
      .clr_i (~rst_n),
      .inc_i (pass_hit[c]),
      .cnt_o (pass_cnt[c*P_CNT_WIDTH +: P_CNT_WIDTH])
    );
    dutb_sat_counter #(.P_W(P_CNT_WIDTH), .P_INC_W(1)) u_fail (
      .clk_i (clk),
      .clr_i (~rst_n),
      .inc_i (fail_hit[c]),
      .cnt_o (fail_cnt[c*P_CNT_WIDTH +: P_CNT_WIDTH])
    );
  end

  dutb_sat_counter #(.P_W(FW), .P_INC_W(IW), .P_MAX(FW'(P_MAX_FAIL_NUM))) u_total (
    .clk_i (clk),
    .clr_i (~rst_n),
    .inc_i (fail_inc),
    .cnt_o (fail_total)
  );

  // Evaluated on the unclipped next total so stop_req rises with fail_total.
  assign budget_hit = (P_MAX_FAIL_NUM != 0) && (state_q == ST_RUN) &&
                      ((int'(fail_total) + int'(fail_inc)) >= P_MAX_FAIL_NUM);

`ifdef DUTB_FAIL_MON_TIMEOUT_EN
  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = '0;
    if ((state_q == ST_RUN) && !(|chk_valid)) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign timeout_hit = (state_q == ST_RUN) && !(|chk_valid) && (tmr_q == TW'(P_TIMEOUT - 1));
`else
  // No idle timer in this build; the comparison is constant false for legal P_TIMEOUT.
  assign timeout_hit = (P_TIMEOUT < 0);
`endif

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    stop_req_d = stop_req_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (budget_hit) begin
          state_d    = ST_DRAIN;
          cause_d    = STOP_FAIL;
          stop_req_d = 1'b1;
        end else if (timeout_hit) begin
          state_d    = ST_DRAIN;
          cause_d    = STOP_TIMEOUT;
          stop_req_d = 1'b1;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (stop_ack) begin
        state_d    = ST_STOPPED;
        stop_req_d = 1'b0;
        done_d     = 1'b1;
      end
      ST_STOPPED: state_d = ST_STOPPED;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cause_q    <= STOP_NONE;
      stop_req_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      stop_req_q <= stop_req_d;
      done_q     <= done_d;
    end
  end

  assign stop_req   = stop_req_q;
  assign stop_cause = cause_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dutb_fail_monitor.sv
// Self-checking bench for dutb_fail_monitor: per-cycle reference model plus directed
// scenarios with literal expectations (budget, clipping, drain, saturation, reset, timeout).
module tb_dutb_fail_monitor;
  import dutb_param_pkg::*;

  localparam int CH   = 4;
  localparam int BUD  = 4;
  localparam int CW   = 4;
  localparam int TO   = 8;
  localparam int FW   = fail_total_width(BUD);
  localparam int MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [CH-1:0]     chk_valid = '0;
  logic [CH-1:0]     chk_pass = '0;
  logic [CH*CW-1:0]  pass_cnt;
  logic [CH*CW-1:0]  fail_cnt;
  logic [FW-1:0]     fail_total;
  logic              stop_req;
  logic              stop_ack = 1'b0;
  logic [1:0]        stop_cause;
  logic              done;

  dutb_fail_monitor #(
    .P_CH_NUM(CH), .P_MAX_FAIL_NUM(BUD), .P_CNT_WIDTH(CW), .P_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_total(fail_total),
    .stop_req(stop_req), .stop_ack(stop_ack), .stop_cause(stop_cause), .done(done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pc(input int c);
    return int'(pass_cnt[c*CW +: CW]);
  endfunction

  function automatic int fc(input int c);
    return int'(fail_cnt[c*CW +: CW]);
  endfunction

  // Reference model: mode 0 idle, 1 run, 2 drain, 3 stopped.
  int m_pass[CH];
  int m_fail[CH];
  int m_total, m_mode, m_cause, m_stop, m_done;
  int cyc = 0;
  int last_evt = 0;

  always @(posedge clk) begin
    int inc;
    bit any_v, to_hit;
    cyc++;
    if (!rst_n) begin
      foreach (m_pass[c]) begin m_pass[c] = 0; m_fail[c] = 0; end
      m_total = 0; m_mode = 0; m_cause = 0; m_stop = 0; m_done = 0;
    end else begin
      any_v = (chk_valid != '0);
      if (m_mode == 1 || m_mode == 2) begin
        inc = 0;
        for (int c = 0; c < CH; c++) begin
          if (chk_valid[c]) begin
            if (chk_pass[c]) m_pass[c] = (m_pass[c] < MAXC) ? m_pass[c] + 1 : MAXC;
            else begin
              m_fail[c] = (m_fail[c] < MAXC) ? m_fail[c] + 1 : MAXC;
              inc++;
            end
          end
        end
        m_total = (m_total + inc > BUD) ? BUD : m_total + inc;
      end
      case (m_mode)
        0: if (enable) begin m_mode = 1; last_evt = cyc; end
        1: begin
          to_hit = 0;
`ifdef DUTB_FAIL_MON_TIMEOUT_EN
          to_hit = !any_v && ((cyc - last_evt) >= TO);
`endif
          if (BUD != 0 && m_total >= BUD) begin m_mode = 2; m_stop = 1; m_cause = 1; end
          else if (to_hit)                begin m_mode = 2; m_stop = 1; m_cause = 2; end
          else if (!enable)               m_mode = 0;
          if (any_v) last_evt = cyc;
        end
        2: if (stop_ack) begin m_mode = 3; m_stop = 0; m_done = 1; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("model pass_cnt[%0d]", c), pc(c), m_pass[c]);
        check($sformatf("model fail_cnt[%0d]", c), fc(c), m_fail[c]);
      end
      check("model fail_total", int'(fail_total), m_total);
      check("model stop_req",   int'(stop_req),   m_stop);
      check("model stop_cause", int'(stop_cause), m_cause);
      check("model done",       int'(done),       m_done);
    end
  end

  task automatic step(input logic [CH-1:0] v, input logic [CH-1:0] p);
    chk_valid = v;
    chk_pass  = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(4'h0, 4'h0);
    step(4'h0, 4'h0);
    chk_en = 1;
    check("reset fail_total", int'(fail_total), 0);
    check("reset stop_req", int'(stop_req), 0);
    check("reset stop_cause", int'(stop_cause), 0);
    check("reset done", int'(done), 0);
    check("reset pass_cnt", int'(pass_cnt), 0);

    // Budget reached by four separate ch0 fails, then drain handshake.
    rst_n = 1; enable = 1;
    step(4'h0, 4'h0);
    repeat (3) begin step(4'h1, 4'h0); step(4'h2, 4'h2); end
    check("pre budget fail_total", int'(fail_total), 3);
    check("pre budget stop_req", int'(stop_req), 0);
    step(4'h1, 4'h0);
    check("budget fail_total", int'(fail_total), 4);
    check("budget stop_req", int'(stop_req), 1);
    check("budget stop_cause", int'(stop_cause), 1);
    check("budget fail ch0", fc(0), 4);
    check("budget pass ch1", pc(1), 3);
    repeat (5) step(4'h4, 4'h4);
    check("drain pass ch2", pc(2), 5);
    check("drain stop_req", int'(stop_req), 1);
    check("drain done", int'(done), 0);
    stop_ack = 1;
    step(4'h4, 4'h4);
    stop_ack = 0;
    check("ack done", int'(done), 1);
    check("ack stop_req", int'(stop_req), 0);
    check("ack pass ch2", pc(2), 6);
    repeat (3) step(4'h5, 4'h4);
    check("stopped pass ch2", pc(2), 6);
    check("stopped fail ch0", fc(0), 4);
    check("stopped stop_cause", int'(stop_cause), 1);

    // Reset out of STOPPED; IDLE ignores verdicts.
    rst_n = 0; enable = 0;
    step(4'h0, 4'h0);
    rst_n = 1;
    check("rst done", int'(done), 0);
    check("rst stop_cause", int'(stop_cause), 0);
    check("rst fail ch0", fc(0), 0);
    step(4'hF, 4'hF);
    step(4'hF, 4'h0);
    check("idle pass ch0", pc(0), 0);
    check("idle fail_total", int'(fail_total), 0);

    // Multi-channel overshoot clipped at the budget.
    enable = 1;
    step(4'h0, 4'h0);
    repeat (3) step(4'h2, 4'h0);
    check("clip pre total", int'(fail_total), 3);
    check("clip pre stop_req", int'(stop_req), 0);
    step(4'hF, 4'h0);
    check("clip fail_total", int'(fail_total), 4);
    check("clip fail ch0", fc(0), 1);
    check("clip fail ch1", fc(1), 4);
    check("clip fail ch3", fc(3), 1);
    check("clip stop_req", int'(stop_req), 1);
    check("clip stop_cause", int'(stop_cause), 1);

    // Reset pulse while in DRAIN.
    rst_n = 0;
    step(4'h0, 4'h0);
    rst_n = 1; enable = 0;
    check("drain rst stop_req", int'(stop_req), 0);
    check("drain rst fail_total", int'(fail_total), 0);
    check("drain rst fail ch1", fc(1), 0);
    check("drain rst stop_cause", int'(stop_cause), 0);

    // Per-channel saturation.
    enable = 1;
    step(4'h0, 4'h0);
    repeat (20) step(4'h2, 4'h2);
    check("sat pass ch1", pc(1), 15);
    check("sat fail ch1", fc(1), 0);

    // enable falling returns to IDLE, counters hold.
    enable = 0;
    step(4'h2, 4'h2);
    step(4'h1, 4'h0);
    check("disable fail ch0", fc(0), 0);
    check("disable pass ch1", pc(1), 15);
    check("disable stop_req", int'(stop_req), 0);

    // Idle timeout after a single verdict.
    enable = 1;
    step(4'h0, 4'h0);
    step(4'h1, 4'h1);
    check("timeout pass ch0", pc(0), 1);
    repeat (7) step(4'h0, 4'h0);
    check("timeout pre stop_req", int'(stop_req), 0);
    step(4'h0, 4'h0);
`ifdef DUTB_FAIL_MON_TIMEOUT_EN
    check("timeout stop_req", int'(stop_req), 1);
    check("timeout stop_cause", int'(stop_cause), 2);
    stop_ack = 1;
    step(4'h0, 4'h0);
    stop_ack = 0;
    check("timeout done", int'(done), 1);
`else
    repeat (92) step(4'h0, 4'h0);
    check("no timer stop_req", int'(stop_req), 0);
    check("no timer stop_cause", int'(stop_cause), 0);
`endif

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
